// File: rtl/conv_window_feeder.sv
// conv_window_feeder: buffers two image lines and emits one 3x3 window
// per valid raster position on in/en.
// Ports: clk, reset (async, active low), start/img_width/img_height
// frame setup, pix_in/pix_valid/pix_ready pixel stream,
// in/en window output, busy and frame_done status.
module conv_window_feeder #(
   parameter int cell_bit = 8,
   parameter int N_cell   = 9,
   parameter int MAX_W    = 32,
   parameter int DIM_BITS = 6
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [DIM_BITS-1:0]        img_width,
   input  logic [DIM_BITS-1:0]        img_height,
   input  logic [cell_bit-1:0]        pix_in,
   input  logic                       pix_valid,
   output logic                       pix_ready,
   output logic [cell_bit*N_cell-1:0] in,
   output logic                       en,
   output logic                       busy,
   output logic                       frame_done
);

   localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [DIM_BITS-1:0] D_ONE  = DIM_BITS'(1);
   localparam logic [DIM_BITS-1:0] D_TWO  = DIM_BITS'(2);
   localparam logic [DIM_BITS-1:0] D_THR  = DIM_BITS'(3);
   localparam logic [DIM_BITS-1:0] D_MAXW = DIM_BITS'(MAX_W);

   logic [1:0]          state;
   logic [DIM_BITS-1:0] w_q;
   logic [DIM_BITS-1:0] h_q;
   logic [DIM_BITS-1:0] row;
   logic [DIM_BITS-1:0] col;

   logic [cell_bit-1:0] line_a [MAX_W];
   logic [cell_bit-1:0] line_b [MAX_W];
   logic [cell_bit-1:0] win    [N_cell];

   logic [AW-1:0]       idx;
   logic [cell_bit-1:0] top_new;
   logic [cell_bit-1:0] mid_new;
   logic                accept;
   logic                last_col;
   logic                last_row;
   logic                legal;

   assign idx      = col[AW-1:0];
   assign top_new  = line_a[idx];
   assign mid_new  = line_b[idx];
   assign accept   = (state == S_RUN) && pix_valid;
   assign last_col = (col == w_q - D_ONE);
   assign last_row = (row == h_q - D_ONE);
   assign legal    = (img_width >= D_THR) &&
                     (img_width <= D_MAXW) &&
                     (img_height >= D_THR);

   assign pix_ready  = (state == S_RUN);
   assign busy       = (state == S_RUN);
   assign frame_done = (state == S_DONE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         w_q   <= '0;
         h_q   <= '0;
         row   <= '0;
         col   <= '0;
         en    <= 1'b0;
      end else begin
         en <= 1'b0;
         unique case (1'b1)
            (state == S_IDLE): begin
               if (start && legal) begin
                  w_q   <= img_width;
                  h_q   <= img_height;
                  row   <= '0;
                  col   <= '0;
                  state <= S_RUN;
               end
            end
            (state == S_RUN): begin
               if (pix_valid) begin
                  // window becomes complete once two full rows and
                  // two columns of the current row are behind us
                  en <= (row >= D_TWO) && (col >= D_TWO);
                  if (last_col) begin
                     col <= '0;
                     row <= row + D_ONE;
                     if (last_row)
                        state <= S_DONE;
                  end else begin
                     col <= col + D_ONE;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // shift columns left; new right column comes from the two line
   // buffers (rows r-2, r-1) plus the incoming pixel (row r)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < N_cell; k++)
            win[k] <= '0;
      end else if (accept) begin
         for (int r = 0; r < 3; r++) begin
            win[3*r]   <= win[3*r+1];
            win[3*r+1] <= win[3*r+2];
         end
         win[2] <= top_new;
         win[5] <= mid_new;
         win[8] <= pix_in;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         line_a[idx] <= mid_new;
         line_b[idx] <= pix_in;
      end
   end

   always_comb begin
      in = '0;
      for (int k = 0; k < N_cell; k++)
         in[k*cell_bit +: cell_bit] = win[k];
   end

endmodule

// File: tb/tb_conv_window_feeder.sv
// tb_conv_window_feeder: directed scenarios for conv_window_feeder,
// checking window values, en timing, framing and reset behaviour.
module tb_conv_window_feeder;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [5:0]  img_width;
   logic [5:0]  img_height;
   logic [7:0]  pix_in;
   logic        pix_valid;
   logic        pix_ready;
   logic [71:0] in_w;
   logic        en;
   logic        busy;
   logic        frame_done;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int done_cnt = 0;
   int done_cyc = -1;
   logic [71:0] wq [$];
   int          ecq [$];

   always #5 clk = ~clk;

   conv_window_feeder dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .img_width  (img_width),
      .img_height (img_height),
      .pix_in     (pix_in),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .in         (in_w),
      .en         (en),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (en === 1'b1) begin
         wq.push_back(in_w);
         ecq.push_back(cyc);
      end
      if (frame_done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   function automatic logic [71:0] exp_win(int r, int c, int w,
                                           int base, bit by_col);
      logic [71:0] v;
      int rr, cc, p;
      v = '0;
      for (int k = 0; k < 9; k++) begin
         rr = r - 2 + k / 3;
         cc = c - 2 + k % 3;
         p  = by_col ? cc : base + rr * w + cc;
         v[k*8 +: 8] = 8'(p);
      end
      return v;
   endfunction

   task automatic clear_mon();
      @(negedge clk);
      wq.delete();
      ecq.delete();
      done_cnt = 0;
      done_cyc = -1;
   endtask

   task automatic push(input logic [7:0] v, input logic vld,
                       input logic st, output int e);
      @(negedge clk);
      pix_in    = v;
      pix_valid = vld;
      start     = st;
      e         = cyc + 1;
   endtask

   task automatic stop();
      @(negedge clk);
      pix_valid = 1'b0;
      start     = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         pix_valid = 1'b0;
         start     = 1'b0;
      end
   endtask

   task automatic do_start(input logic [5:0] w, input logic [5:0] h);
      @(negedge clk);
      start      = 1'b1;
      img_width  = w;
      img_height = h;
      pix_valid  = 1'b0;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; pix_valid = 1'b0;
      pix_in = '0; img_width = '0; img_height = '0;
      #1;
      total++;
      if ({pix_ready, busy, en, frame_done} !== 4'b0) begin
         bad++;
         $display("FAIL reset_ctl got=%b exp=0000",
                  {pix_ready, busy, en, frame_done});
      end
      total++;
      if (in_w !== 72'h0) begin
         bad++;
         $display("FAIL reset_in got=%h exp=0", in_w);
      end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      total++;
      if ({pix_ready, busy, en, frame_done} !== 4'b0) begin
         bad++;
         $display("FAIL post_reset_ctl got=%b exp=0000",
                  {pix_ready, busy, en, frame_done});
      end
   endtask

   task automatic test_basic();
      int e [16];
      int pos [4] = '{10, 11, 14, 15};
      clear_mon();
      do_start(6'd4, 6'd4);
      for (int i = 0; i < 16; i++) push(8'(i), 1'b1, 1'b0, e[i]);
      stop();
      total++;
      if ({frame_done, busy, pix_ready} !== 3'b100) begin
         bad++;
         $display("FAIL basic_done_state got=%b exp=100",
                  {frame_done, busy, pix_ready});
      end
      idle(3);
      total++;
      if (wq.size() !== 4) begin
         bad++;
         $display("FAIL basic_count got=%0d exp=4", wq.size());
      end
      for (int n = 0; n < 4 && n < wq.size(); n++) begin
         total++;
         if (ecq[n] !== e[pos[n]]) begin
            bad++;
            $display("FAIL basic_en_cyc%0d got=%0d exp=%0d",
                     n, ecq[n], e[pos[n]]);
         end
         total++;
         if (wq[n] !== exp_win(2 + n / 2, 2 + n % 2, 4, 0, 1'b0)) begin
            bad++;
            $display("FAIL basic_win%0d got=%h exp=%h", n, wq[n],
                     exp_win(2 + n / 2, 2 + n % 2, 4, 0, 1'b0));
         end
      end
      if (wq.size() == 4) begin
         total++;
         if (wq[0] !== 72'h0a0908060504020100) begin
            bad++;
            $display("FAIL basic_first got=%h exp=0a0908060504020100",
                     wq[0]);
         end
         total++;
         if (wq[3] !== 72'h0f0e0d0b0a09070605) begin
            bad++;
            $display("FAIL basic_last got=%h exp=0f0e0d0b0a09070605",
                     wq[3]);
         end
      end
      total++;
      if (done_cnt !== 1 || done_cyc !== e[15]) begin
         bad++;
         $display("FAIL basic_done got=%0d@%0d exp=1@%0d",
                  done_cnt, done_cyc, e[15]);
      end
   endtask

   task automatic test_gaps();
      int e [16];
      int dummy;
      int pos [4] = '{10, 11, 14, 15};
      clear_mon();
      do_start(6'd4, 6'd4);
      for (int i = 0; i < 16; i++) begin
         push(8'(i), 1'b1, 1'b0, e[i]);
         if (i < 15) push(8'hee, 1'b0, 1'b0, dummy);
      end
      stop();
      idle(3);
      total++;
      if (wq.size() !== 4) begin
         bad++;
         $display("FAIL gaps_count got=%0d exp=4", wq.size());
      end
      for (int n = 0; n < 4 && n < wq.size(); n++) begin
         total++;
         if (ecq[n] !== e[pos[n]]) begin
            bad++;
            $display("FAIL gaps_en_cyc%0d got=%0d exp=%0d",
                     n, ecq[n], e[pos[n]]);
         end
         total++;
         if (wq[n] !== exp_win(2 + n / 2, 2 + n % 2, 4, 0, 1'b0)) begin
            bad++;
            $display("FAIL gaps_win%0d got=%h exp=%h", n, wq[n],
                     exp_win(2 + n / 2, 2 + n % 2, 4, 0, 1'b0));
         end
      end
   endtask

   task automatic test_wide();
      int dummy;
      clear_mon();
      do_start(6'd32, 6'd3);
      for (int i = 0; i < 96; i++)
         push(8'(i % 32), 1'b1, 1'b0, dummy);
      stop();
      idle(3);
      total++;
      if (wq.size() !== 30) begin
         bad++;
         $display("FAIL wide_count got=%0d exp=30", wq.size());
      end
      for (int n = 0; n < 30 && n < wq.size(); n++) begin
         total++;
         if (wq[n] !== exp_win(2, n + 2, 32, 0, 1'b1)) begin
            bad++;
            $display("FAIL wide_win%0d got=%h exp=%h", n, wq[n],
                     exp_win(2, n + 2, 32, 0, 1'b1));
         end
      end
      total++;
      if (done_cnt !== 1) begin
         bad++;
         $display("FAIL wide_done got=%0d exp=1", done_cnt);
      end
   endtask

   task automatic test_illegal();
      logic [5:0] ws [3] = '{6'd2, 6'd5, 6'd33};
      logic [5:0] hs [3] = '{6'd5, 6'd2, 6'd3};
      int hi;
      for (int t = 0; t < 3; t++) begin
         clear_mon();
         do_start(ws[t], hs[t]);
         hi = 0;
         repeat (50) begin
            @(negedge clk);
            pix_valid = 1'b1;
            pix_in    = 8'h55;
            if (pix_ready !== 1'b0 || busy !== 1'b0) hi++;
         end
         pix_valid = 1'b0;
         idle(2);
         total++;
         if (hi !== 0) begin
            bad++;
            $display("FAIL illegal%0d_active got=%0d exp=0", t, hi);
         end
         total++;
         if (wq.size() !== 0 || done_cnt !== 0) begin
            bad++;
            $display("FAIL illegal%0d_out got=%0d/%0d exp=0/0",
                     t, wq.size(), done_cnt);
         end
      end
   endtask

   task automatic test_reset_mid();
      int dummy;
      clear_mon();
      do_start(6'd5, 6'd5);
      for (int i = 0; i < 7; i++) push(8'(i), 1'b1, 1'b0, dummy);
      stop();
      total++;
      if (busy !== 1'b1 || in_w === 72'h0) begin
         bad++;
         $display("FAIL mid_pre got=%b/%h exp=1/nonzero", busy, in_w);
      end
      #2 reset = 1'b0;
      #1;
      total++;
      if ({pix_ready, busy, en, frame_done} !== 4'b0 ||
          in_w !== 72'h0) begin
         bad++;
         $display("FAIL mid_async got=%b/%h exp=0000/0",
                  {pix_ready, busy, en, frame_done}, in_w);
      end
      @(negedge clk);
      reset = 1'b1;
      idle(2);
      clear_mon();
      do_start(6'd3, 6'd3);
      for (int i = 0; i < 9; i++) push(8'(100 + i), 1'b1, 1'b0, dummy);
      stop();
      idle(3);
      total++;
      if (wq.size() !== 1) begin
         bad++;
         $display("FAIL mid_count got=%0d exp=1", wq.size());
      end
      if (wq.size() > 0) begin
         total++;
         if (wq[0] !== 72'h6c6b6a696867666564) begin
            bad++;
            $display("FAIL mid_win got=%h exp=6c6b6a696867666564", wq[0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int dummy;
      logic [71:0] ew [3];
      ew[0] = exp_win(2, 2, 3, 10, 1'b0);
      ew[1] = exp_win(2, 2, 4, 50, 1'b0);
      ew[2] = exp_win(2, 3, 4, 50, 1'b0);
      clear_mon();
      do_start(6'd3, 6'd3);
      for (int i = 0; i < 9; i++) push(8'(10 + i), 1'b1, 1'b0, dummy);
      stop();
      total++;
      if (frame_done !== 1'b1) begin
         bad++;
         $display("FAIL b2b_done1 got=%b exp=1", frame_done);
      end
      do_start(6'd4, 6'd3);
      img_width  = 6'd3;
      img_height = 6'd3;
      for (int i = 0; i < 12; i++)
         push(8'(50 + i), 1'b1, (i == 5), dummy);
      stop();
      idle(3);
      total++;
      if (wq.size() !== 3 || done_cnt !== 2) begin
         bad++;
         $display("FAIL b2b_count got=%0d/%0d exp=3/2",
                  wq.size(), done_cnt);
      end
      for (int n = 0; n < 3 && n < wq.size(); n++) begin
         total++;
         if (wq[n] !== ew[n]) begin
            bad++;
            $display("FAIL b2b_win%0d got=%h exp=%h", n, wq[n], ew[n]);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_basic();
      test_gaps();
      test_wide();
      test_illegal();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
